// File: rtl/tmds_word_slip_if.sv
// Signal bundle between the TMDS deserializer/monitor side and the word-slip aligner.
// bitslip is a fire-and-forget request; slip_ack pulses once per accepted request and dropped requests get no ack.
interface tmds_word_slip_if #(
    parameter int WRAP_W = 8
);
    logic [9:0]        din;
    logic              bitslip;
    logic [9:0]        dout;
    logic              dout_valid;
    logic [3:0]        offset;
    logic              slip_ack;
    logic [WRAP_W-1:0] wrap_cnt;

    modport master (
        output din, bitslip,
        input  dout, dout_valid, offset, slip_ack, wrap_cnt
    );

    modport slave (
        input  din, bitslip,
        output dout, dout_valid, offset, slip_ack, wrap_cnt
    );
endinterface

// File: rtl/tmds_word_slip.sv
// Per-channel TMDS word-boundary aligner: re-frames raw 10-bit words by a slip offset
// and masks dout_valid while the new framing settles.
module tmds_word_slip #(
    parameter int SETTLE_CYC = 4,
    parameter int WRAP_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    tmds_word_slip_if.slave  sif
);
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYC);

    logic [9:0]        din_d;
    logic [19:0]       win;
    logic [9:0]        dout_q;
    logic [9:0]        dout_nxt;
    logic              valid_q;
    logic [3:0]        offset_q;
    logic              ack_q;
    logic [WRAP_W-1:0] wrap_q;
    logic [3:0]        settle_q;
    logic              accept;

    // Window holds the previous word in the low half so win[0] is the oldest bit.
    assign win    = {sif.din, din_d};
    assign accept = sif.bitslip && (settle_q == 4'd0);

    // One 10:1 mux per output bit instead of a barrel shifter.
    always_comb begin
        dout_nxt = '0;
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 10; k++) begin
                if (offset_q == 4'(k)) begin
                    dout_nxt[i] = win[i + k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            din_d    <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            offset_q <= 4'd0;
            ack_q    <= 1'b0;
            wrap_q   <= '0;
            settle_q <= SETTLE_INIT;
        end else begin
            din_d   <= sif.din;
            dout_q  <= dout_nxt;
            valid_q <= (settle_q == 4'd0) && !accept;
            ack_q   <= accept;
            if (accept) begin
                offset_q <= (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
                settle_q <= SETTLE_INIT;
                if (offset_q == 4'd9 && wrap_q != '1) begin
                    wrap_q <= wrap_q + 1'b1;
                end
            end else if (settle_q != 4'd0) begin
                settle_q <= settle_q - 4'd1;
            end
        end
    end

    assign sif.dout       = dout_q;
    assign sif.dout_valid = valid_q;
    assign sif.offset     = offset_q;
    assign sif.slip_ack   = ack_q;
    assign sif.wrap_cnt   = wrap_q;
endmodule

// File: tb/tb_tmds_word_slip.sv
// Directed bench for tmds_word_slip: reset timing, latency, slip/settle behaviour,
// dropped slips, wrap saturation and reset during a settle window.
module tb_tmds_word_slip;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   acks;

    tmds_word_slip_if #(.WRAP_W(8)) sif ();

    tmds_word_slip #(.SETTLE_CYC(4), .WRAP_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One accepted slip followed by the full settle window; 16 cycles total.
    task automatic do_slip(input int exp_off);
        sif.bitslip = 1'b1;
        tick();
        sif.bitslip = 1'b0;
        check("slip_ack_pulse", 32'(sif.slip_ack), 32'd1);
        check("slip_offset", 32'(sif.offset), 32'(exp_off));
        check("slip_valid_drop", 32'(sif.dout_valid), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("settle_ack_low", 32'(sif.slip_ack), 32'd0);
            check("settle_valid_low", 32'(sif.dout_valid), 32'd0);
        end
        tick();
        check("settle_valid_back", 32'(sif.dout_valid), 32'd1);
        repeat (10) tick();
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        acks        = 0;
        rst         = 1'b1;
        sif.din     = 10'h000;
        sif.bitslip = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_dout", 32'(sif.dout), 32'h0);
        check("rst_valid", 32'(sif.dout_valid), 32'd0);
        check("rst_offset", 32'(sif.offset), 32'd0);
        check("rst_ack", 32'(sif.slip_ack), 32'd0);
        check("rst_wrap", 32'(sif.wrap_cnt), 32'd0);

        // Static stream: valid first high at the 5th edge after release
        rst     = 1'b0;
        sif.din = 10'h354;
        for (int n = 1; n <= 5; n++) begin
            tick();
            check("valid_after_reset", 32'(sif.dout_valid), (n == 5) ? 32'd1 : 32'd0);
        end
        check("static_dout", 32'(sif.dout), 32'h354);
        check("static_offset", 32'(sif.offset), 32'd0);
        check("static_wrap", 32'(sif.wrap_cnt), 32'd0);

        // Two-edge latency at offset 0
        sif.din = 10'h0AA;
        tick();
        sif.din = 10'h155;
        tick();
        check("latency_a", 32'(sif.dout), 32'h0AA);
        sif.din = 10'h3FF;
        tick();
        check("latency_b", 32'(sif.dout), 32'h155);

        // 0x354 framed 3 bits late arrives as the constant word 0x2A6
        sif.din = 10'h2A6;
        tick();
        tick();
        check("late_unaligned", 32'(sif.dout), 32'h2A6);
        do_slip(1);
        do_slip(2);
        do_slip(3);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("aligned_valid", 32'(sif.dout_valid), 32'd1);
            check("aligned_dout", 32'(sif.dout), 32'h354);
        end

        // Ten slips from offset 0 wrap once
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check("pre_wrap_offset", 32'(sif.offset), 32'd0);
        for (int k = 1; k <= 10; k++) begin
            do_slip(k % 10);
        end
        check("wrap_once", 32'(sif.wrap_cnt), 32'd1);

        // bitslip held high: accepts every 5 edges, 3000 accepts = 300 more wraps
        sif.bitslip = 1'b1;
        for (int e = 1; e <= 15000; e++) begin
            tick();
            if (sif.slip_ack) acks++;
            if (e == 2500) begin
                check("hold_acks_mid", 32'(acks), 32'd500);
                check("wrap_mid", 32'(sif.wrap_cnt), 32'd51);
            end
        end
        sif.bitslip = 1'b0;
        check("hold_acks_total", 32'(acks), 32'd3000);
        check("hold_offset", 32'(sif.offset), 32'd0);
        check("wrap_saturated", 32'(sif.wrap_cnt), 32'd255);
        tick();

        // Second request inside settle is dropped
        sif.bitslip = 1'b1;
        tick();
        sif.bitslip = 1'b0;
        check("drop_first_ack", 32'(sif.slip_ack), 32'd1);
        check("drop_first_offset", 32'(sif.offset), 32'd1);
        tick();
        sif.bitslip = 1'b1;
        tick();
        sif.bitslip = 1'b0;
        check("drop_second_ack", 32'(sif.slip_ack), 32'd0);
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (sif.slip_ack) acks++;
        end
        check("drop_no_late_ack", 32'(acks), 32'd0);
        check("drop_offset", 32'(sif.offset), 32'd1);
        check("drop_wrap", 32'(sif.wrap_cnt), 32'd255);

        // Reset two cycles into a settle window with bitslip high
        sif.bitslip = 1'b1;
        tick();
        sif.bitslip = 1'b0;
        check("mid_slip_offset", 32'(sif.offset), 32'd2);
        tick();
        tick();
        rst         = 1'b1;
        sif.bitslip = 1'b1;
        tick();
        check("mid_rst_offset", 32'(sif.offset), 32'd0);
        check("mid_rst_dout", 32'(sif.dout), 32'h0);
        check("mid_rst_valid", 32'(sif.dout_valid), 32'd0);
        check("mid_rst_ack", 32'(sif.slip_ack), 32'd0);
        check("mid_rst_wrap", 32'(sif.wrap_cnt), 32'd0);
        rst         = 1'b0;
        sif.bitslip = 1'b0;
        sif.din     = 10'h354;
        for (int n = 1; n <= 5; n++) begin
            tick();
            check("valid_after_mid_rst", 32'(sif.dout_valid), (n == 5) ? 32'd1 : 32'd0);
        end
        check("post_rst_dout", 32'(sif.dout), 32'h354);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tmds_word_slip.md
Name: tmds_word_slip

Overview:
Per-channel TMDS word-boundary aligner. It sits between the 1:10 deserializer and the phase-alignment monitor. It takes raw 10-bit parallel words with an arbitrary bit-boundary offset and outputs re-framed 10-bit words. Each accepted bitslip request from the downstream monitor advances the boundary by one bit. Output is marked invalid while the new framing settles.

Parameters:
SETTLE_CYC, 4, cycles of forced dout_valid=0 after each accepted slip and after reset; legal range 2..15.
WRAP_W, 8, width of the saturating full-rotation counter.

Ports:
clk  in  1  sole clock, pixel-rate word clock.
rst  in  1  synchronous, active-high reset.
din  in  10  raw deserializer word; din[0] is the earliest received bit.
bitslip  in  1  single-cycle request to advance the word boundary by one bit.
dout  out  10  re-framed word; dout[0] is the earliest bit.
dout_valid  out  1  high when dout uses settled framing.
offset  out  4  current boundary offset, 0..9.
slip_ack  out  1  one-cycle pulse when a bitslip is accepted.
wrap_cnt  out  WRAP_W  count of offset 9->0 wraps, saturating.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high. All state updates occur on the rising edge of clk.
- Reset values: din_d=0, dout=0, dout_valid=0, offset=0, slip_ack=0, wrap_cnt=0, settle_cnt=SETTLE_CYC.
- Window register: din_d <= din every cycle. Window w = {din, din_d} is 20 bits, with w[0] the oldest bit.
- Output register: dout <= w[offset +: 10] every cycle, using the offset value at that edge. Implement as a 10:1 mux per output bit; no variable shifter wider than 20 bits.
- Latency: din to dout is 2 cycles at offset 0. At offset 0, dout equals din from two edges earlier.
- Slip accept: accept = bitslip && (settle_cnt==0). On an accepting edge:
  - offset <= (offset==9) ? 0 : offset+1.
  - settle_cnt <= SETTLE_CYC.
  - slip_ack <= 1 (0 otherwise).
  - If offset==9, wrap_cnt increments, saturating at all-ones.
- Non-accepted bitslip (settle_cnt!=0) is dropped silently. It is not queued, and offset, slip_ack and wrap_cnt are unchanged. The monitor issues slips at most once per timeout period, far longer than the settle window, so dropping is safe.
- Settle counter: decrements by 1 per edge while nonzero and no accept occurs.
- Valid register: dout_valid <= (settle_cnt==0) && !accept.
  - After an accepting edge T, dout_valid is 0 for SETTLE_CYC+1 cycles. It returns to 1 at edge T+SETTLE_CYC+1.
  - After reset deassertion, the first high dout_valid is at the (SETTLE_CYC+1)th edge.
- offset is driven directly from the offset register. The value visible after an accepting edge is the new offset.
- Reset has priority over accept. rst high mid-settle or mid-slip forces all reset values on that edge, including settle_cnt reload.
- Simultaneous rst and bitslip: reset wins; no slip_ack.
- dout continues to update while dout_valid=0. Downstream must qualify dout with dout_valid.

Test Plan:
- Reset then static stream din=0x354 each cycle -> dout_valid first high at the 5th edge after rst release, dout=0x354, offset=0, wrap_cnt=0.
- Serial stream of repeating 0x354 framed 3 bits late; issue 3 bitslips spaced 16 cycles apart -> three slip_ack pulses, offset=3, and dout=0x354 on every valid cycle after the 3rd settle.
- Single bitslip at edge T -> slip_ack high for one cycle after T; dout_valid low exactly 5 cycles and back high at edge T+5.
- bitslip at T, then again at T+2 (inside settle) -> second request ignored: one slip_ack, offset increments by 1 only.
- 10 spaced bitslips from offset 0 -> offset sequence 1..9,0; wrap_cnt=1. Force 300 wraps -> wrap_cnt saturates at 255.
- rst asserted 2 cycles into a settle window with bitslip high -> on that edge offset=0, dout=0, dout_valid=0, slip_ack=0; normal valid timing restarts from release.
